led_anim_writer: RTL and testbench
==================================

# led_anim_writer

Animation source for the badge LED intensity buffer. It is the writer side of the 11-LED x 3-colour, 8-bit-per-entry intensity array that the PWM cathode/RGB-sink scanner reads. On each frame tick it sweeps all 33 entries once over a valid/ready write port, then advances its animation state. Supported modes are clear, chase, breathe and rainbow.

## Interface
- NUM_LEDS, 11, LED count; `wr_led` indexes 0..NUM_LEDS-1.
- NUM_COLORS, 3, colour planes per LED; `wr_color` is 0=red, 1=green, 2=blue (logical colour, before per-LED pin remap).
- TICK_DIV, 65536, clocks per frame tick; minimum 64.
- STEP, 4, per-frame increment for breathe level and rainbow phase; range 1..255.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  frame sweeps start only while high.
- mode  in  2  0=clear, 1=chase, 2=breathe, 3=rainbow; sampled at frame start.
- wr_valid  out  1  write entry presented.
- wr_ready  in  1  buffer accepts the entry this cycle.
- wr_led  out  4  LED index.
- wr_color  out  2  colour plane.
- wr_data  out  8  intensity, 0x00=off, 0xFF=full.
- busy  out  1  frame sweep in progress.
- frame_done  out  1  one-cycle pulse after the last entry of a frame is accepted.

## Operation
- Reset values:
  - Outputs: all outputs 0.
  - Animation state: tick counter 0; chase pos=0, hue=0; breathe level=0x00, dir=up; phase=0x00.
  - FSM: WAIT.
- Tick counter: free-runs 0..TICK_DIV-1 and wraps. `tick` is high while the count equals TICK_DIV-1. It runs in every state.
- FSM states:
  - WAIT: on `tick && en`, latch `mode`, set index (led=0, color=0) and go to WRITE.
  - WRITE: present the entry. On `wr_ready`, advance the index, colour first (innermost), then LED. When the accepted entry is (NUM_LEDS-1, 2), go to DONE.
  - DONE: pulse `frame_done`, update animation state, return to WAIT.
- Entry order: (0,0),(0,1),(0,2),(1,0)…(10,2); 33 writes per frame.
- Data per latched mode:
  - clear: 0x00 for every entry.
  - chase: 0xFF where led==pos and color==hue, otherwise 0x00. In DONE, pos increments. When pos wraps NUM_LEDS-1→0, hue steps 0→1→2→0.
  - breathe: every entry = level. In DONE, level moves by STEP in direction dir. Compute in 9 bits and clamp to 0x00..0xFF. On reaching 0xFF dir becomes down; on reaching 0x00 dir becomes up.
  - rainbow: data = (phase + led*23 + color*85) mod 256. In DONE, phase = (phase+STEP) mod 256.
- State update rules:
  - All animation state is kept and updated only in DONE, for the latched mode only.
  - A frame in any mode leaves the other modes' state untouched.
- Boundary behaviour:
  - Mode change mid-frame: ignored until the next frame start.
  - en low mid-frame: the current frame completes; no new frame starts.
  - Tick while busy: dropped; no queuing, no catch-up.
  - rst mid-frame: all outputs drop to 0 immediately. The next sweep restarts at entry (0,0) on the first tick after release.

## Timing
- Frame start: tick at edge T in WAIT → `wr_valid`=1 and `busy`=1 from cycle T+1 with entry (0,0).
- Handshake:
  - Once `wr_valid` is high, `wr_led`/`wr_color`/`wr_data` stay stable until `wr_ready` is sampled high.
  - The transfer occurs on an edge where valid && ready.
  - The next entry appears in the following cycle with valid kept high (no bubble).
  - No combinational path from `wr_ready` to any output.
- With `wr_ready` tied high: 33 consecutive valid cycles, then `frame_done` in the next cycle.
- Last acceptance at edge K:
  - cycle K+1: `wr_valid`=0, `frame_done`=1, `busy`=1.
  - cycle K+2: `busy`=0.
  - New animation state is visible from the next frame's first entry.
- Worst-case frame duration must be under TICK_DIV for full frame rate; otherwise ticks are dropped as above.

## Test plan
- Reset: assert rst mid-sweep with `wr_valid`=1 → all outputs 0 in the same cycle. After release, the first tick yields entry (0,0) one cycle later.
- Clear mode, TICK_DIV=64, `wr_ready`=1 → 33 writes in 33 consecutive cycles, order (0,0)…(10,2), all data 0x00, then exactly one `frame_done` pulse. Repeats every 64 cycles.
- Random `wr_ready` backpressure (~50%), rainbow mode, STEP=4:
  - Address and data stay stable while valid && !ready; exactly 33 transfers per frame.
  - Frame 0 entry (1,2) = 23+170 = 0xC1; frame 1 entry (1,2) = 0xC5.
- Chase mode:
  - Frame 0: only (0,0)=0xFF.
  - Frame 10: only (10,0)=0xFF.
  - Frame 11: only (0,1)=0xFF.
  - Frame 33: only (0,0)=0xFF again.
- Breathe mode, STEP=64 → per-frame levels 0x00,0x40,0x80,0xC0,0xFF,0xBF,0x7F,0x3F,0x00,0x40; all 33 entries equal within each frame.
- Mode switched and en dropped mid-frame → current frame completes with the old mode and `frame_done` pulses. No further frame starts while en=0. The new mode applies at the first frame after en returns high.

Source files
------------

// File: rtl/led_anim_writer.sv
// Writer side of the badge LED intensity buffer: once per frame tick, sweeps all
// LED/colour entries over a valid/ready port, then advances the animation state.
module led_anim_writer #(
    parameter int NUM_LEDS   = 11,
    parameter int NUM_COLORS = 3,
    parameter int TICK_DIV   = 65536,
    parameter int STEP       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [3:0] wr_led,
    output logic [1:0] wr_color,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(TICK_DIV);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] M_CLEAR   = 2'd0;
    localparam logic [1:0] M_CHASE   = 2'd1;
    localparam logic [1:0] M_BREATHE = 2'd2;
    localparam logic [1:0] M_RAINBOW = 2'd3;

    logic [CW-1:0] cnt_reg;
    logic [1:0]    state_reg;
    logic [1:0]    mode_reg;
    logic [3:0]    led_reg;
    logic [1:0]    color_reg;
    logic [3:0]    pos_reg;
    logic [1:0]    hue_reg;
    logic [7:0]    level_reg;
    logic          dir_down_reg;
    logic [7:0]    phase_reg;

    logic          tick;
    logic          last_entry;
    logic [8:0]    level_up;
    logic [7:0]    level_next;
    logic          dir_down_next;
    logic [7:0]    rainbow_val;
    logic [7:0]    data_val;

    assign tick       = (cnt_reg == CW'(TICK_DIV - 1));
    assign last_entry = (led_reg == 4'(NUM_LEDS - 1)) && (color_reg == 2'(NUM_COLORS - 1));
    assign level_up   = {1'b0, level_reg} + 9'(STEP);

    // Breathe level moves in 9 bits so that overshoot in either direction clamps.
    always_comb begin
        level_next    = level_reg;
        dir_down_next = dir_down_reg;
        if (!dir_down_reg) begin
            if (level_up >= 9'h0FF) begin
                level_next    = 8'hFF;
                dir_down_next = 1'b1;
            end else begin
                level_next = level_up[7:0];
            end
        end else begin
            if ({1'b0, level_reg} <= 9'(STEP)) begin
                level_next    = 8'h00;
                dir_down_next = 1'b0;
            end else begin
                level_next = level_reg - 8'(STEP);
            end
        end
    end

    assign rainbow_val = phase_reg + 8'(led_reg) * 8'd23 + 8'(color_reg) * 8'd85;

    always_comb begin
        data_val = 8'h00;
        case (mode_reg)
            M_CLEAR:   data_val = 8'h00;
            M_CHASE:   data_val = (led_reg == pos_reg && color_reg == hue_reg) ? 8'hFF : 8'h00;
            M_BREATHE: data_val = level_reg;
            M_RAINBOW: data_val = rainbow_val;
            default:   data_val = 8'h00;
        endcase
    end

    // Every output derives from registers only; wr_ready never reaches them combinationally.
    assign wr_valid   = (state_reg == S_WRITE);
    assign busy       = (state_reg != S_WAIT);
    assign frame_done = (state_reg == S_DONE);
    assign wr_led     = led_reg;
    assign wr_color   = color_reg;
    assign wr_data    = wr_valid ? data_val : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_WAIT;
            mode_reg     <= M_CLEAR;
            led_reg      <= '0;
            color_reg    <= '0;
            pos_reg      <= '0;
            hue_reg      <= '0;
            level_reg    <= 8'h00;
            dir_down_reg <= 1'b0;
            phase_reg    <= 8'h00;
        end else begin
            case (state_reg)
                S_WAIT: begin
                    if (tick && en) begin
                        mode_reg  <= mode;
                        led_reg   <= '0;
                        color_reg <= '0;
                        state_reg <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        // Index returns to (0,0) after the last entry so idle outputs read zero.
                        if (last_entry) begin
                            led_reg   <= '0;
                            color_reg <= '0;
                            state_reg <= S_DONE;
                        end else if (color_reg == 2'(NUM_COLORS - 1)) begin
                            color_reg <= '0;
                            led_reg   <= led_reg + 1'b1;
                        end else begin
                            color_reg <= color_reg + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_WAIT;
                    case (mode_reg)
                        M_CHASE: begin
                            if (pos_reg == 4'(NUM_LEDS - 1)) begin
                                pos_reg <= '0;
                                hue_reg <= (hue_reg == 2'(NUM_COLORS - 1)) ? 2'd0 : hue_reg + 1'b1;
                            end else begin
                                pos_reg <= pos_reg + 1'b1;
                            end
                        end
                        M_BREATHE: begin
                            level_reg    <= level_next;
                            dir_down_reg <= dir_down_next;
                        end
                        M_RAINBOW: phase_reg <= phase_reg + 8'(STEP);
                        default: ;
                    endcase
                end
                default: state_reg <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_led_anim_writer.sv
// Directed bench for led_anim_writer: two instances (STEP=4 and STEP=64) share stimulus;
// one task per scenario, each comparing captured frames against hand-derived values.
module tb_led_anim_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       wr_ready = 1'b1;

    logic       a_valid, a_busy, a_done, b_valid, b_busy, b_done;
    logic [3:0] a_led, b_led;
    logic [1:0] a_color, b_color;
    logic [7:0] a_data, b_data;

    led_anim_writer #(.NUM_LEDS(11), .NUM_COLORS(3), .TICK_DIV(64), .STEP(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .wr_valid(a_valid), .wr_ready(wr_ready), .wr_led(a_led), .wr_color(a_color),
        .wr_data(a_data), .busy(a_busy), .frame_done(a_done)
    );

    led_anim_writer #(.NUM_LEDS(11), .NUM_COLORS(3), .TICK_DIV(64), .STEP(64)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .wr_valid(b_valid), .wr_ready(wr_ready), .wr_led(b_led), .wr_color(b_color),
        .wr_data(b_data), .busy(b_busy), .frame_done(b_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    bit use_b = 1'b0;
    bit rand_ready = 1'b0;
    int sw_at = -1;

    logic       m_valid, m_busy, m_done;
    logic [3:0] m_led;
    logic [1:0] m_color;
    logic [7:0] m_data;
    assign m_valid = use_b ? b_valid : a_valid;
    assign m_busy  = use_b ? b_busy  : a_busy;
    assign m_done  = use_b ? b_done  : a_done;
    assign m_led   = use_b ? b_led   : a_led;
    assign m_color = use_b ? b_color : a_color;
    assign m_data  = use_b ? b_data  : a_data;

    logic [3:0] cap_led[33];
    logic [1:0] cap_color[33];
    logic [7:0] cap_data[33];
    int         cap_cycles, cap_viol, cap_start;
    bit         cap_timeout;
    logic       cap_done1, cap_valid1, cap_busy1, cap_done2, cap_busy2;

    // Collects one frame's transfers (called at a negedge); also records hold violations.
    task automatic capture();
        int n;
        int w;
        logic held;
        logic [14:0] hv;
        n = 0; w = 0; held = 1'b0; hv = '0;
        cap_timeout = 1'b0; cap_viol = 0; cap_cycles = 0;
        while (!m_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!m_valid) begin
            cap_timeout = 1'b1;
            return;
        end
        cap_start = cyc;
        while (n < 33 && cap_cycles < 3000) begin
            if (held && {m_valid, m_led, m_color, m_data} !== hv) cap_viol++;
            if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
            held = 1'b0;
            if (m_valid) begin
                if (wr_ready) begin
                    cap_led[n]   = m_led;
                    cap_color[n] = m_color;
                    cap_data[n]  = m_data;
                    n++;
                    if (n == sw_at) begin
                        mode = 2'd1;
                        en   = 1'b0;
                    end
                end else begin
                    held = 1'b1;
                    hv   = {1'b1, m_led, m_color, m_data};
                end
            end
            cap_cycles++;
            @(negedge clk);
        end
        if (n < 33) cap_timeout = 1'b1;
        wr_ready   = 1'b1;
        cap_done1  = m_done;
        cap_valid1 = m_valid;
        cap_busy1  = m_busy;
        @(negedge clk);
        cap_done2 = m_done;
        cap_busy2 = m_busy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int w;
        mode = 2'd0; en = 1'b1; wr_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a_valid, a_busy, a_done, a_led, a_color, a_data} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {a_valid, a_busy, a_done, a_led, a_color, a_data});
        end
        rst = 1'b0;
        w = 0;
        while (!a_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w !== 64 || {a_led, a_color} !== 6'd0) begin
            errors++;
            $display("FAIL reset_first_tick: latency %0d entry (%0d,%0d) expected 64 (0,0)", w, a_led, a_color);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (a_valid !== 1'b1 || a_led !== 4'd1) begin
            errors++;
            $display("FAIL midsweep_setup: valid %b led %0d expected 1 1", a_valid, a_led);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_valid, a_busy, a_done, a_led, a_color, a_data} !== 17'd0) begin
            errors++;
            $display("FAIL reset_midsweep: got %h expected 0", {a_valid, a_busy, a_done, a_led, a_color, a_data});
        end
        @(negedge clk);
        rst = 1'b0;
        w = 0;
        while (!a_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w !== 64 || {a_led, a_color} !== 6'd0) begin
            errors++;
            $display("FAIL reset_restart: latency %0d entry (%0d,%0d) expected 64 (0,0)", w, a_led, a_color);
        end
    endtask

    task automatic test_clear();
        int start0;
        mode = 2'd0; en = 1'b1; wr_ready = 1'b1;
        do_reset();
        capture();
        start0 = cap_start;
        checks++;
        if (cap_timeout || cap_cycles !== 33) begin
            errors++;
            $display("FAIL clear_cycles: timeout %b cycles %0d expected 0 33", cap_timeout, cap_cycles);
        end
        for (int i = 0; i < 33; i++) begin
            checks++;
            if ({cap_led[i], cap_color[i], cap_data[i]} !== {4'(i / 3), 2'(i % 3), 8'h00}) begin
                errors++;
                $display("FAIL clear_entry%0d: got (%0d,%0d)=%h expected (%0d,%0d)=00",
                         i, cap_led[i], cap_color[i], cap_data[i], i / 3, i % 3);
            end
        end
        checks++;
        if ({cap_done1, cap_valid1, cap_busy1, cap_done2, cap_busy2} !== 5'b10100) begin
            errors++;
            $display("FAIL clear_done_pulse: done,valid,busy,done2,busy2 %b expected 10100",
                     {cap_done1, cap_valid1, cap_busy1, cap_done2, cap_busy2});
        end
        capture();
        checks++;
        if (cap_timeout || cap_start - start0 !== 64) begin
            errors++;
            $display("FAIL clear_period: got %0d expected 64", cap_start - start0);
        end
    endtask

    task automatic test_rainbow();
        logic [7:0] exp_d;
        mode = 2'd3; en = 1'b1; rand_ready = 1'b1;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            capture();
            checks++;
            if (cap_timeout || cap_viol !== 0) begin
                errors++;
                $display("FAIL rainbow_handshake%0d: timeout %b hold violations %0d expected 0 0", f, cap_timeout, cap_viol);
            end
            checks++;
            if (cap_data[5] !== (f == 0 ? 8'hC1 : 8'hC5)) begin
                errors++;
                $display("FAIL rainbow_entry_1_2_f%0d: got %h expected %h", f, cap_data[5], (f == 0 ? 8'hC1 : 8'hC5));
            end
            for (int i = 0; i < 33; i++) begin
                exp_d = 8'((4 * f + (i / 3) * 23 + (i % 3) * 85) % 256);
                checks++;
                if ({cap_led[i], cap_color[i], cap_data[i]} !== {4'(i / 3), 2'(i % 3), exp_d}) begin
                    errors++;
                    $display("FAIL rainbow_f%0d_e%0d: got (%0d,%0d)=%h expected (%0d,%0d)=%h",
                             f, i, cap_led[i], cap_color[i], cap_data[i], i / 3, i % 3, exp_d);
                end
            end
        end
        rand_ready = 1'b0;
        wr_ready = 1'b1;
    endtask

    task automatic test_chase();
        int pos;
        int hue;
        logic [7:0] exp_d;
        mode = 2'd1; en = 1'b1; wr_ready = 1'b1;
        do_reset();
        for (int f = 0; f <= 33; f++) begin
            capture();
            if (f == 0 || f == 10 || f == 11 || f == 33) begin
                pos = f % 11;
                hue = (f / 11) % 3;
                checks++;
                if (cap_timeout) begin
                    errors++;
                    $display("FAIL chase_timeout_f%0d: got timeout expected frame", f);
                end
                for (int i = 0; i < 33; i++) begin
                    exp_d = (i / 3 == pos && i % 3 == hue) ? 8'hFF : 8'h00;
                    checks++;
                    if (cap_data[i] !== exp_d) begin
                        errors++;
                        $display("FAIL chase_f%0d_e%0d: got %h expected %h", f, i, cap_data[i], exp_d);
                    end
                end
            end
        end
    endtask

    task automatic test_breathe();
        logic [7:0] levels[10];
        levels = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00, 8'h40};
        use_b = 1'b1;
        mode = 2'd2; en = 1'b1; wr_ready = 1'b1;
        do_reset();
        for (int f = 0; f < 10; f++) begin
            capture();
            for (int i = 0; i < 33; i++) begin
                checks++;
                if (cap_timeout || cap_data[i] !== levels[f]) begin
                    errors++;
                    $display("FAIL breathe_f%0d_e%0d: got %h expected %h", f, i, cap_data[i], levels[f]);
                end
            end
        end
        use_b = 1'b0;
    endtask

    task automatic test_mode_switch();
        int bcount;
        logic [7:0] exp_d;
        mode = 2'd3; en = 1'b1; wr_ready = 1'b1;
        do_reset();
        sw_at = 10;
        capture();
        sw_at = -1;
        for (int i = 0; i < 33; i++) begin
            exp_d = 8'(((i / 3) * 23 + (i % 3) * 85) % 256);
            checks++;
            if (cap_timeout || cap_data[i] !== exp_d) begin
                errors++;
                $display("FAIL switch_oldmode_e%0d: got %h expected %h", i, cap_data[i], exp_d);
            end
        end
        checks++;
        if (cap_done1 !== 1'b1) begin
            errors++;
            $display("FAIL switch_done: got %b expected 1", cap_done1);
        end
        bcount = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (a_busy || a_valid) bcount++;
        end
        checks++;
        if (bcount !== 0) begin
            errors++;
            $display("FAIL switch_idle: busy cycles %0d expected 0", bcount);
        end
        en = 1'b1;
        capture();
        for (int i = 0; i < 33; i++) begin
            exp_d = (i == 0) ? 8'hFF : 8'h00;
            checks++;
            if (cap_timeout || cap_data[i] !== exp_d) begin
                errors++;
                $display("FAIL switch_newmode_e%0d: got %h expected %h", i, cap_data[i], exp_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_rainbow();
        test_chase();
        test_breathe();
        test_mode_switch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
